// File: rtl/trisc_pkg.sv
// trisc_pkg: opcodes, sequencer states and instruction field layout shared by TRISC blocks.
package trisc_pkg;
    localparam int OPC_MSB = 7;
    localparam int OPC_LSB = 4;
    localparam int OPR_MSB = 3;
    localparam int OPR_LSB = 0;
    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_CLR  = 4'h1;
    localparam logic [3:0] OP_LDA  = 4'h2;
    localparam logic [3:0] OP_LDB  = 4'h3;
    localparam logic [3:0] OP_INC  = 4'h4;
    localparam logic [3:0] OP_JMP  = 4'h5;
    localparam logic [3:0] OP_JZ   = 4'h6;
    localparam logic [3:0] OP_OUT  = 4'h7;
    localparam logic [3:0] OP_HALT = 4'hF;
    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_EXEC, S_HALT} state_t;
    function automatic logic [3:0] opcode(input logic [7:0] ins);
        return ins[OPC_MSB:OPC_LSB];
    endfunction
    function automatic logic [3:0] operand(input logic [7:0] ins);
        return ins[OPR_MSB:OPR_LSB];
    endfunction
endpackage

// File: rtl/trisc_opdec.sv
// trisc_opdec: combinational decode of the instruction register into accumulator and flow controls.
module trisc_opdec
    import trisc_pkg::*;
#(
    parameter int DW = 4
) (
    input  logic [7:0]    i_ir,
    output logic          o_clear,
    output logic          o_load,
    output logic          o_inc,
    output logic          o_ab,
    output logic [DW-1:0] o_imm,
    output logic          o_jmp,
    output logic          o_jz,
    output logic          o_out,
    output logic          o_halt
);
    logic [3:0] w_op;
    assign w_op    = opcode(i_ir);
    assign o_clear = w_op == OP_CLR;
    assign o_load  = (w_op == OP_LDA) || (w_op == OP_LDB);
    assign o_inc   = w_op == OP_INC;
    assign o_ab    = w_op == OP_LDB;
    assign o_imm   = (w_op == OP_LDA) ? DW'(operand(i_ir)) : '0;
    assign o_jmp   = w_op == OP_JMP;
    assign o_jz    = w_op == OP_JZ;
    assign o_out   = w_op == OP_OUT;
    assign o_halt  = w_op == OP_HALT;
endmodule

// File: rtl/trisc_seq.sv
// trisc_seq: TRISC fetch/execute sequencer driving accumulator strobes and a valid/ready output port.
module trisc_seq
    import trisc_pkg::*;
#(
    parameter int PW = 4,
    parameter int DW = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    output logic [PW-1:0] pc,
    input  logic [7:0]    instr,
    output logic          acc_clear,
    output logic          acc_load,
    output logic          acc_inc,
    output logic          acc_ab,
    output logic [DW-1:0] imm,
    input  logic [DW-1:0] acc_q,
    output logic [DW-1:0] out_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          halted
);
    state_t        r_state;
    logic [PW-1:0] r_pc;
    logic [7:0]    r_ir;
    logic [DW-1:0] r_out_data;
    logic          w_exec, w_clear, w_load, w_inc, w_ab, w_jmp, w_jz, w_out, w_halt, w_jump;
    logic [DW-1:0] w_imm;

    trisc_opdec #(.DW(DW)) u_dec (
        .i_ir    (r_ir),
        .o_clear (w_clear),
        .o_load  (w_load),
        .o_inc   (w_inc),
        .o_ab    (w_ab),
        .o_imm   (w_imm),
        .o_jmp   (w_jmp),
        .o_jz    (w_jz),
        .o_out   (w_out),
        .o_halt  (w_halt)
    );

    // Outputs depend only on state and IR, so async reset clears them at once.
    assign w_exec    = r_state == S_EXEC;
    assign w_jump    = w_jmp || (w_jz && acc_q == '0);
    assign acc_clear = w_exec && w_clear;
    assign acc_load  = w_exec && w_load;
    assign acc_inc   = w_exec && w_inc;
    assign acc_ab    = w_exec && w_ab;
    assign imm       = w_exec ? w_imm : '0;
    assign out_valid = w_exec && w_out;
    assign out_data  = r_out_data;
    assign halted    = r_state == S_HALT;
    assign pc        = r_pc;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_pc       <= '0;
            r_ir       <= '0;
            r_out_data <= '0;
        end else begin
            case (r_state)
                S_IDLE, S_HALT: begin
                    if (start) begin
                        r_state <= S_FETCH;
                        r_pc    <= '0;
                    end
                end
                S_FETCH: begin
                    r_ir    <= instr;
                    r_pc    <= r_pc + 1'b1;
                    r_state <= S_EXEC;
                    if (opcode(instr) == OP_OUT) r_out_data <= acc_q;
                end
                S_EXEC: begin
                    if (w_jump) r_pc <= PW'(operand(r_ir));
                    if (w_halt) r_state <= S_HALT;
                    else if (!w_out || out_ready) r_state <= S_FETCH;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_trisc_seq.sv
// tb_trisc_seq: directed and random programs checked against an instruction-level model of TRISC.
module tb_trisc_seq;
    logic       clk = 0, reset = 0, start = 0, out_ready = 0;
    logic [3:0] pc, imm, acc_q, out_data;
    logic [7:0] instr;
    logic       acc_clear, acc_load, acc_inc, acc_ab, out_valid, halted;
    logic [7:0] rom [16];
    logic       rdy [128];
    logic [3:0] bval = 0;
    logic [3:0] acc = 0;
    logic [3:0] got_q[$], exp_q[$];
    int errors = 0, checks = 0;
    int ovl, stab, vcnt, lcnt;
    logic mon_en = 0, pv, phs;
    logic [3:0] pd;

    trisc_seq dut (
        .clk(clk), .reset(reset), .start(start), .pc(pc), .instr(instr),
        .acc_clear(acc_clear), .acc_load(acc_load), .acc_inc(acc_inc), .acc_ab(acc_ab),
        .imm(imm), .acc_q(acc_q), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .halted(halted)
    );

    always #5 clk = ~clk;
    assign instr = rom[pc];
    assign acc_q = acc;

    always @(posedge clk or posedge reset) begin
        if (reset) acc <= 0;
        else if (acc_clear) acc <= 0;
        else if (acc_load) acc <= acc_ab ? bval : imm;
        else if (acc_inc) acc <= acc + 4'd1;
    end

    always @(negedge clk) begin
        if (mon_en) begin
            if (32'(acc_clear) + 32'(acc_load) + 32'(acc_inc) > 1) ovl++;
            if (acc_load) lcnt++;
            if (out_valid) begin
                vcnt++;
                if (pv && !phs && out_data !== pd) stab++;
                if (out_ready) got_q.push_back(out_data);
            end
            pv = out_valid;
            pd = out_data;
            phs = out_valid && out_ready;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Instruction-level reference: each instruction costs a fetch cycle and an execute
    // cycle, OUT extends execute until the ready sampled in that cycle is high.
    task automatic model(input int n, output logic [3:0] mpc, output logic mh, output logic [3:0] macc);
        int t = 0;
        logic [7:0] ins;
        logic [3:0] cap;
        mpc = 0; mh = 0; macc = 0;
        exp_q.delete();
        while (t < n && !mh) begin
            ins = rom[mpc];
            mpc = mpc + 4'd1;
            t++;
            if (t >= n) break;
            case (ins[7:4])
                4'h1: macc = 0;
                4'h2: macc = ins[3:0];
                4'h3: macc = bval;
                4'h4: macc = macc + 4'd1;
                4'h5: mpc = ins[3:0];
                4'h6: if (macc == 0) mpc = ins[3:0];
                4'hF: mh = 1;
                default: ;
            endcase
            if (ins[7:4] == 4'h7) begin
                cap = macc;
                while (t < n) begin
                    t++;
                    if (rdy[t-1]) begin
                        exp_q.push_back(cap);
                        break;
                    end
                end
            end else t++;
        end
    endtask

    task automatic run(input string tag, input int n);
        logic [3:0] mpc, macc;
        logic mh;
        @(negedge clk);
        mon_en = 0; reset = 1;
        @(negedge clk);
        reset = 0;
        got_q.delete();
        ovl = 0; stab = 0; vcnt = 0; lcnt = 0; pv = 0; phs = 0; pd = 0;
        mon_en = 1; start = 1;
        @(posedge clk);
        #1 start = 0;
        for (int c = 0; c < n; c++) begin
            out_ready = rdy[c];
            @(posedge clk);
            #1;
        end
        mon_en = 0;
        model(n, mpc, mh, macc);
        chk({tag, ".pc"}, 32'(pc), 32'(mpc));
        chk({tag, ".halted"}, 32'(halted), 32'(mh));
        chk({tag, ".acc"}, 32'(acc), 32'(macc));
        chk({tag, ".ntx"}, got_q.size(), exp_q.size());
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            chk({tag, ".tx"}, 32'(got_q[i]), 32'(exp_q[i]));
        chk({tag, ".overlap"}, ovl, 0);
        chk({tag, ".stable"}, stab, 0);
    endtask

    task automatic load(input logic [7:0] p [$]);
        for (int i = 0; i < 16; i++) rom[i] = i < p.size() ? p[i] : 8'h00;
    endtask

    task automatic all_ready(input logic v);
        for (int i = 0; i < 128; i++) rdy[i] = v;
    endtask

    initial begin
        load('{});
        all_ready(1);
        reset = 1;
        #2;
        chk("reset_outs", {28'(pc), acc_clear, acc_load, acc_inc, acc_ab, 4'(imm), out_valid, 4'(out_data), halted},
            0);
        #10 reset = 0;

        load('{8'h25, 8'h40, 8'h70, 8'hF0});
        run("p1_7cyc", 7);
        chk("p1_not_yet_halted", 32'(halted), 0);
        run("p1", 8);
        chk("p1_halted", 32'(halted), 1);
        chk("p1_data", got_q.size() == 1 ? 32'(got_q[0]) : 32'hFFFF, 6);

        load('{8'h10, 8'h64, 8'h21, 8'h70, 8'h70, 8'hF0});
        run("p2", 20);
        chk("p2_no_load", lcnt, 0);

        load('{8'h29, 8'h70, 8'hF0});
        for (int i = 3; i < 8; i++) rdy[i] = 0;
        run("stall", 14);
        chk("stall_valid_cycles", vcnt, 6);
        all_ready(1);

        for (int i = 0; i < 16; i++) rom[i] = 8'h40;
        run("inc16", 40);

        load('{8'h23, 8'h70, 8'hF0});
        all_ready(0);
        run("rst_pre", 6);
        @(negedge clk);
        chk("rst_pre_valid", 32'(out_valid), 1);
        reset = 1;
        #1;
        chk("rst_mid_outs", {pc, acc_clear, acc_load, acc_inc, out_valid}, 0);
        all_ready(1);
        run("rst_rerun", 8);

        bval = 4'hC;
        load('{8'hA5, 8'h30, 8'hF0});
        @(negedge clk); reset = 1;
        @(negedge clk); reset = 0; start = 1;
        @(negedge clk); start = 0;
        @(negedge clk);
        chk("resv_strobes", {acc_clear, acc_load, acc_inc, acc_ab}, 0);
        @(negedge clk);
        @(negedge clk);
        chk("ldb_strobes", {acc_clear, acc_load, acc_inc, acc_ab}, 4'b0101);
        run("resv_ldb", 6);

        for (int r = 0; r < 20; r++) begin
            bval = 4'($urandom);
            for (int i = 0; i < 16; i++) rom[i] = 8'($urandom);
            for (int i = 0; i < 128; i++) rdy[i] = $urandom_range(0, 3) != 0;
            run("rand", 80);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/trisc_seq.md
# trisc_seq

Instruction sequencer for the TRISC datapath: fetches 8-bit instructions from a 16-entry program ROM and drives the accumulator's control inputs (clear, load, inc, A/B select). It is the controlling end of the accumulator interface: the accumulator only obeys strobes, and this block decides when they fire. It also emits the accumulator value on an output port with a valid/ready handshake.

## Interface
Parameters:
- `PW`, 4, program counter width (ROM depth 2^PW)
- `DW`, 4, accumulator/data width

Ports:
- `clk`  in  1  rising-edge clock; the block's only clock
- `reset`  in  1  asynchronous, active-high reset
- `start`  in  1  leave IDLE/HALT and begin fetching at PC 0
- `pc`  out  PW  ROM address
- `instr`  in  8  ROM data, combinational from `pc`; `[7:4]` opcode, `[3:0]` operand
- `acc_clear`, `acc_load`, `acc_inc`, `acc_ab`  out  1 each  accumulator controls (`acc_ab`=0 selects A, 1 selects B)
- `imm`  out  DW  operand driven to accumulator A input
- `acc_q`  in  DW  accumulator output
- `out_data`  out  DW  output port data
- `out_valid`  out  1  output port valid
- `out_ready`  in  1  output port ready
- `halted`  out  1  high in HALT

## Operation
- States: IDLE, FETCH, EXEC, HALT.
- IDLE: `start`=1 -> FETCH with pc=0. HALT: `start`=1 -> FETCH with pc=0. `start` is ignored in FETCH/EXEC.
- FETCH (1 cycle): IR <= `instr`; pc <= pc+1 (wraps 15->0); -> EXEC.
- EXEC, decoded from IR opcode:
  - 0 NOP: no strobes.
  - 1 CLR: `acc_clear`=1.
  - 2 LDA: `acc_load`=1, `acc_ab`=0, `imm`=operand.
  - 3 LDB: `acc_load`=1, `acc_ab`=1.
  - 4 INC: `acc_inc`=1 (accumulator wraps 15->0).
  - 5 JMP: pc <= operand.
  - 6 JZ: if `acc_q`==0 then pc <= operand, else pc unchanged.
  - 7 OUT: `out_valid`=1, `out_data`=`acc_q` captured on entry to EXEC; stays in EXEC until `out_valid`&&`out_ready`.
  - F HALT: -> HALT.
  - 8-E: reserved, execute as NOP.
- All strobes are one-cycle pulses in EXEC only; at most one of clear/load/inc is high in any cycle.
- Strobes, `imm` and `acc_ab` are decoded from the registered IR and state only, with no combinational path from `acc_q` or `out_ready`.
- After EXEC completes -> FETCH (except HALT).

## Timing
- Reset values: state IDLE, pc 0, IR 0, all strobes 0, `imm` 0, `acc_ab` 0, `out_valid` 0, `out_data` 0, `halted` 0.
- Non-OUT instruction: exactly 2 cycles (FETCH, EXEC); the accumulator updates on the clock edge ending EXEC.
- JZ samples `acc_q` during its EXEC cycle, so it sees the result of the preceding instruction.
- OUT: `out_valid` rises the cycle EXEC is entered. `out_data` is held stable while `out_valid`=1 and `out_ready`=0. The transfer completes on the edge where both are 1; `out_valid` is 0 the next cycle (FETCH). Minimum 2 cycles, unbounded if stalled.
- Reset asserted mid-OUT or mid-EXEC: all outputs go to reset values immediately (asynchronous); no strobe survives reset.
- pc wraps 15->0 with no fault indication.

## Structure
- `trisc_pkg`: opcode constants (OP_NOP..OP_HALT), state enum, instruction field positions. The package is shared with assembler tests and future TRISC blocks.
- One sub-module, `trisc_opdec`: a combinational IR -> strobe/imm/ab/jump/out/halt decode. FSM, PC and IR stay in `trisc_seq`.

## Test plan
- Program {LDA 5, INC, OUT, HALT}, `out_ready`=1: one transfer with `out_data`=6; `halted`=1 after 8 cycles from `start`.
- {CLR, JZ 4, LDA 1, OUT, OUT, HALT}: JZ is taken, pc goes to 4, one OUT of 0; the LDA strobe never fires.
- OUT with `out_ready` held low for 5 cycles: `out_valid` stays 1 and `out_data` stays stable for 6 cycles; exactly one transfer.
- Program of 16 INCs with no HALT: pc wraps to 0 and the accumulator wraps; no strobe overlap over 40 cycles.
- Reset pulsed during an OUT stall: `out_valid`, pc and strobes are 0 in the same cycle; `start` reruns from pc 0.
- Reserved opcode 0xA followed by LDB: no strobe in the 0xA EXEC cycle; LDB gives `acc_load`=1 with `acc_ab`=1.
